// File: rtl/denormalizer.sv
// Denormalizer: reconstructs eight signed integer samples as norm*STD + MEAN, saturated, one channel per cycle.
// Latency: o_finished pulses 8 cycles after the accepting edge; o_data commits on that same edge.
// Backpressure: none; i_start is ignored while busy. Optional DENORM_ROUND_EN selects round-half-away-from-zero.
module denormalizer (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic signed [15:0] i_norm [0:7],
    output logic signed [15:0] o_data [0:7],
    output logic               o_busy,
    output logic               o_finished
);

    localparam logic signed [15:0] MEAN [0:7] = '{
        16'sh0305, -16'sh0058, 16'sh0101, 16'sh013E,
        16'sh0144,  16'sh014E, 16'sh0154, 16'sh0133
    };
    localparam logic signed [15:0] STD [0:7] = '{
        16'sh01F1, 16'sh00FD, 16'sh0110, 16'sh0013,
        16'sh002D, 16'sh002B, 16'sh0024, 16'sh0029
    };

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic        [2:0]  k;
    logic signed [15:0] norm_q [0:7];
    logic signed [15:0] shadow [0:7];

    logic signed [31:0] prod;
    logic signed [31:0] mag;
    logic signed [31:0] shifted;
    logic signed [31:0] q;
    logic signed [32:0] sum;
    logic signed [15:0] r_sat;

    // Magnitude is shifted so negative products truncate (or round) toward/away from zero symmetrically.
    always_comb begin
        prod = 32'(norm_q[k]) * 32'(STD[k]);
        mag  = (prod < 0) ? -prod : prod;
`ifdef DENORM_ROUND_EN
        shifted = (mag + 32'sd128) >>> 8;
`else
        shifted = mag >>> 8;
`endif
        q   = (prod < 0) ? -shifted : shifted;
        sum = 33'(q) + 33'(MEAN[k]);
        if (sum > 33'sd32767)
            r_sat = 16'sh7FFF;
        else if (sum < -33'sd32768)
            r_sat = -16'sh8000;
        else
            r_sat = sum[15:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = CALC;
            CALC:    if (k == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state      <= IDLE;
            k          <= 3'd0;
            o_finished <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                norm_q[i] <= '0;
                shadow[i] <= '0;
                o_data[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            o_finished <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        norm_q <= i_norm;
                        k      <= 3'd0;
                    end
                end
                CALC: begin
                    shadow[k] <= r_sat;
                    k         <= k + 3'd1;
                    // Channel 7's result has not reached the shadow yet, so it is taken directly.
                    if (k == 3'd7) begin
                        for (int i = 0; i < 7; i++)
                            o_data[i] <= shadow[i];
                        o_data[7]  <= r_sat;
                        o_finished <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/denormalizer.md
DENORMALIZER -- requirements
Module: denormalizer

Interface
REQ-001 SHALL have i_clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have i_rst_n, input, 1, reset, asynchronous, active-high (asserted at 1).
REQ-003 SHALL have i_start, input, 1, request to denormalize i_norm; sampled only in IDLE.
REQ-004 SHALL have i_norm[0:7], input, 8 x 16, signed Q8.8 normalized samples.
REQ-005 SHALL have o_data[0:7], output, 8 x 16, signed integer reconstructed samples.
REQ-006 SHALL have o_busy, output, 1, high whenever the state is not IDLE.
REQ-007 SHALL have o_finished, output, 1, one-cycle pulse when o_data is updated.
REQ-008 SHALL hold constant MEAN[0:7] = 0x0305, -0x0058, 0x0101, 0x013E, 0x0144, 0x014E, 0x0154, 0x0133 (signed 16-bit integer).
REQ-009 SHALL hold constant STD[0:7] = 0x01F1, 0x00FD, 0x0110, 0x0013, 0x002D, 0x002B, 0x0024, 0x0029 (signed 16-bit integer).

Function
REQ-010 SHALL implement states IDLE, CALC, DONE; reset state IDLE.
REQ-011 SHALL, at edge E0 where state=IDLE and i_start=1, capture all eight i_norm into an internal register, clear channel index k to 0, and go to CALC.
REQ-012 SHALL, in CALC, process exactly one channel per edge (E1..E8 -> k=0..7) from the captured copy; i_norm changes after E0 have no effect.
REQ-013 SHALL compute per channel: p = norm[k] * STD[k] as 32-bit signed; q = sign(p) * (|p| >> 8), i.e. truncation toward zero; r = q + MEAN[k].
REQ-014 SHALL saturate r to [-32768, 32767] before storing; no wrap-around.
REQ-015 SHALL store results in a shadow buffer; o_data SHALL NOT change during CALC.
REQ-016 SHALL, at E8 (k=7), copy all eight shadow results to o_data, assert o_finished, and go to DONE.
REQ-017 SHALL, at E9, deassert o_finished and return to IDLE; o_finished is high for exactly one cycle, 8 cycles after the E0 edge.
REQ-018 SHALL ignore i_start while o_busy=1 (E1..E9); no queuing. i_start at E9 is also ignored (state still DONE); the next accepted start is at E10 at the earliest.
REQ-019 SHALL hold o_data at the last committed values indefinitely in IDLE.
REQ-020 SHALL evaluate i_start=1 held continuously as back-to-back requests, one accepted every 10 cycles.

Reset
REQ-021 SHALL, on i_rst_n=1, asynchronously clear o_data (all 0), the shadow buffer, the captured inputs, k, o_busy, and o_finished, and force IDLE.
REQ-022 SHALL abort an in-flight operation on reset mid-CALC or mid-DONE; no o_finished pulse and no o_data update follows.
REQ-023 SHALL accept a new i_start on the first edge after i_rst_n deasserts.

Configuration
REQ-024 SHALL, when DENORM_ROUND_EN is defined, replace REQ-013 truncation with round-half-away-from-zero: q = sign(p) * ((|p| + 128) >> 8).
REQ-025 SHALL, when DENORM_ROUND_EN is undefined, truncate toward zero per REQ-013; timing and interface are identical in both builds.

Verification
REQ-026 SHALL cover: all i_norm=0x0000, start -> o_finished 8 cycles later, o_data = 773, -88, 257, 318, 324, 334, 340, 307.
REQ-027 SHALL cover: i_norm[0]=0x0100, others 0 -> o_data[0]=1270 (0x04F6); i_norm[3]=0xFF80 -> o_data[3]=309 without macro, 308 with DENORM_ROUND_EN.
REQ-028 SHALL cover: i_norm[0]=0x7FFF -> o_data[0]=32767; i_norm[0]=0x8000 -> o_data[0]=-32768 (saturation both ends).
REQ-029 SHALL cover: i_start pulsed at E3 during CALC and i_norm changed at E2 -> exactly one o_finished pulse, results from the E0 capture.
REQ-030 SHALL cover: reset asserted at E5 of an operation -> o_data=0, o_busy=0, no o_finished; new start after release completes normally.
REQ-031 SHALL cover: i_start held high for 30 cycles -> o_finished pulses at E8, E18, E28 relative to the first accept; o_busy low for one cycle between operations.
